usb_in_arbiter: RTL and testbench

USB_IN_ARBITER -- requirements
Module: usb_in_arbiter

---
 rtl/usb_cdc_pkg.sv | 28 ++
 rtl/usb_in_arb_slice.sv | 33 +++
 rtl/usb_in_arbiter.sv | 132 +++++++++++++
 tb/tb_usb_in_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_cdc_pkg.sv
// Shared usb_cdc types: IN-arbiter state encoding and one-hot grant constants.
// States are encoded so that the state value is the grant one-hot itself.
package usb_cdc_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_GRANT0 = 2'b01,
    ARB_GRANT1 = 2'b10
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_S0   = 2'b01;
  localparam logic [1:0] GRANT_S1   = 2'b10;

  localparam int IDLE_CNT_W = 4;

  function automatic logic [1:0] grant_of(input arb_state_e st);
    logic [1:0] g;
    g = GRANT_NONE;
    case (st)
      ARB_GRANT0: g = GRANT_S0;
      ARB_GRANT1: g = GRANT_S1;
      default:    g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/usb_in_arb_slice.sv
// One-entry output register stage: 1-cycle latency, full rate while i_rdy is high;
// accepts a new byte only when empty or draining in the same cycle.
module usb_in_arb_slice (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [7:0] i_dat,
  input  logic       i_vld,
  output logic       o_rdy,
  output logic [7:0] o_dat,
  output logic       o_vld,
  input  logic       i_rdy
);

  logic [7:0] r_dat;
  logic       r_vld;

  assign o_rdy = ~r_vld | i_rdy;
  assign o_dat = r_dat;
  assign o_vld = r_vld;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_vld <= 1'b0;
      r_dat <= 8'h00;
    end else if (i_vld && o_rdy) begin
      r_vld <= 1'b1;
      r_dat <= i_dat;
    end else if (i_rdy) begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/usb_in_arbiter.sv
// Two-source round-robin byte arbiter feeding usb_cdc IN; 1-cycle latency, stalls sources on m_ready_i low.
// USB_IN_ARB_LOCK_EN defined: grants held until last/burst cap/idle; undefined: per-byte round-robin.
module usb_in_arbiter
  import usb_cdc_pkg::*;
#(
  parameter int BURST_LEN    = 8,
  parameter int IDLE_RELEASE = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] s0_data_i,
  input  logic       s0_valid_i,
  input  logic       s0_last_i,
  output logic       s0_ready_o,
  input  logic [7:0] s1_data_i,
  input  logic       s1_valid_i,
  input  logic       s1_last_i,
  output logic       s1_ready_o,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic [1:0] grant_o
);

  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam logic [BC_W-1:0]       BC_MAX = BC_W'(BURST_LEN);
  localparam logic [IDLE_CNT_W-1:0] IC_MAX = IDLE_CNT_W'(IDLE_RELEASE);

`ifdef USB_IN_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [BC_W-1:0]       r_burst_cnt;
  logic [IDLE_CNT_W-1:0] r_idle_cnt;
  logic                  r_rr_s1;

  logic [1:0] w_grant;
  logic [7:0] w_src_dat;
  logic       w_src_vld;
  logic       w_src_last;
  logic       w_slice_rdy;
  logic       w_accept;
  logic       w_burst_done;
  logic       w_idle_done;
  logic       w_release;

  assign w_grant = grant_of(r_state);
  assign grant_o = w_grant;

  always_comb begin
    w_src_dat  = 8'h00;
    w_src_vld  = 1'b0;
    w_src_last = 1'b0;
    if (w_grant[0]) begin
      w_src_dat  = s0_data_i;
      w_src_vld  = s0_valid_i;
      w_src_last = s0_last_i;
    end else if (w_grant[1]) begin
      w_src_dat  = s1_data_i;
      w_src_vld  = s1_valid_i;
      w_src_last = s1_last_i;
    end
  end

  assign w_accept   = w_src_vld & w_slice_rdy;
  assign s0_ready_o = w_grant[0] & w_slice_rdy;
  assign s1_ready_o = w_grant[1] & w_slice_rdy;

  // Both terms look at the current transfer/cycle, so release takes effect on the edge that completes it.
  assign w_burst_done = (r_burst_cnt == (BC_MAX - BC_W'(1)));
  assign w_idle_done  = ~w_src_vld & (r_idle_cnt >= (IC_MAX - IDLE_CNT_W'(1)));
  assign w_release    = (w_accept & (~LOCK_EN | w_src_last | w_burst_done)) | w_idle_done;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (s0_valid_i && s1_valid_i) begin
          w_state_nxt = r_rr_s1 ? ARB_GRANT1 : ARB_GRANT0;
        end else if (s0_valid_i) begin
          w_state_nxt = ARB_GRANT0;
        end else if (s1_valid_i) begin
          w_state_nxt = ARB_GRANT1;
        end
      end
      ARB_GRANT0, ARB_GRANT1: begin
        if (w_release) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) r_state <= ARB_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Counters sit at zero while idle, so every new grant starts from a clean count.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
      r_rr_s1     <= 1'b0;
    end else if (r_state == ARB_IDLE) begin
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
      if (w_state_nxt == ARB_GRANT0)      r_rr_s1 <= 1'b1;
      else if (w_state_nxt == ARB_GRANT1) r_rr_s1 <= 1'b0;
    end else if (w_accept) begin
      r_idle_cnt <= '0;
      if (r_burst_cnt != BC_MAX) r_burst_cnt <= r_burst_cnt + BC_W'(1);
    end else if (!w_src_vld && (r_idle_cnt != IC_MAX)) begin
      r_idle_cnt <= r_idle_cnt + IDLE_CNT_W'(1);
    end
  end

  usb_in_arb_slice u_slice (
    .i_clk  (clk_i),
    .i_rstn (rstn_i),
    .i_dat  (w_src_dat),
    .i_vld  (w_src_vld),
    .o_rdy  (w_slice_rdy),
    .o_dat  (m_data_o),
    .o_vld  (m_valid_o),
    .i_rdy  (m_ready_i)
  );

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Directed bench for usb_in_arbiter: scoreboard on accepted bytes plus a cycle model of grant ownership.
module tb_usb_in_arbiter;

  localparam int BL = 8;
  localparam int IR = 4;
`ifdef USB_IN_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [7:0] s0_data_i, s1_data_i;
  logic       s0_valid_i, s0_last_i, s1_valid_i, s1_last_i;
  logic       s0_ready_o, s1_ready_o;
  logic [7:0] m_data_o;
  logic       m_valid_o, m_ready_i;
  logic [1:0] grant_o;

  usb_in_arbiter #(.BURST_LEN(BL), .IDLE_RELEASE(IR)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .s0_data_i(s0_data_i), .s0_valid_i(s0_valid_i), .s0_last_i(s0_last_i), .s0_ready_o(s0_ready_o),
    .s1_data_i(s1_data_i), .s1_valid_i(s1_valid_i), .s1_last_i(s1_last_i), .s1_ready_o(s1_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  logic [8:0] src0_q[$];
  logic [8:0] src1_q[$];
  logic [7:0] exp_q[$];
  bit s0_hold, s1_hold;
  bit m_rr;
  int m_bc, m_ic;
  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_src(input int src, input logic [7:0] first, input int n, input bit last_end);
    for (int i = 0; i < n; i++) begin
      logic [8:0] e;
      e = {last_end && (i == n - 1), first + 8'(i)};
      if (src == 0) src0_q.push_back(e);
      else          src1_q.push_back(e);
    end
  endtask

  task automatic drive_srcs();
    s0_valid_i = (src0_q.size() != 0) && !s0_hold;
    s0_data_i  = s0_valid_i ? src0_q[0][7:0] : 8'h00;
    s0_last_i  = s0_valid_i ? src0_q[0][8] : 1'b0;
    s1_valid_i = (src1_q.size() != 0) && !s1_hold;
    s1_data_i  = s1_valid_i ? src1_q[0][7:0] : 8'h00;
    s1_last_i  = s1_valid_i ? src1_q[0][8] : 1'b0;
  endtask

  task automatic tick();
    logic [1:0] g, eg;
    logic v0, v1, a0, a1, vn, ln, ov, orr;
    logic [7:0] od, adat;
    bit rel;
    drive_srcs();
    #1;
    g = grant_o; v0 = s0_valid_i; v1 = s1_valid_i;
    chk("s0_ready", 32'(s0_ready_o), 32'(g[0] & (~m_valid_o | m_ready_i)));
    chk("s1_ready", 32'(s1_ready_o), 32'(g[1] & (~m_valid_o | m_ready_i)));
    a0 = v0 & s0_ready_o;
    a1 = v1 & s1_ready_o;
    adat = a0 ? s0_data_i : s1_data_i;
    ov = m_valid_o; orr = m_ready_i; od = m_data_o;
    if (ov && orr) begin
      chk("sb_pending", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) chk("m_data", 32'(od), 32'(exp_q.pop_front()));
    end
    if (a0) begin exp_q.push_back(s0_data_i); void'(src0_q.pop_front()); end
    if (a1) begin exp_q.push_back(s1_data_i); void'(src1_q.pop_front()); end
    eg = g; rel = 1'b0;
    if (g == 2'b00) begin
      if (v0 && v1) eg = m_rr ? 2'b10 : 2'b01;
      else if (v0)  eg = 2'b01;
      else if (v1)  eg = 2'b10;
      if (eg != 2'b00) begin m_rr = (eg == 2'b01); m_bc = 0; m_ic = 0; end
    end else begin
      vn = g[0] ? v0 : v1;
      ln = g[0] ? s0_last_i : s1_last_i;
      if (a0 || a1) begin
        m_bc++; m_ic = 0;
        rel = !LOCK || ln || (m_bc >= BL);
      end else if (!vn) begin
        if (m_ic < IR) m_ic++;
        rel = (m_ic >= IR);
      end
      if (rel) eg = 2'b00;
    end
    @(posedge clk_i); #1;
    n_cyc++;
    chk("grant", 32'(grant_o), 32'(eg));
    if (a0 || a1) begin
      chk("lat_valid", 32'(m_valid_o), 32'(1));
      chk("lat_data", 32'(m_data_o), 32'(adat));
    end else if (ov && !orr) begin
      chk("hold_valid", 32'(m_valid_o), 32'(1));
      chk("hold_data", 32'(m_data_o), 32'(od));
    end
  endtask

  task automatic do_reset(input int n);
    rstn_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive_srcs();
      @(posedge clk_i); #1;
    end
    chk("rst_grant", 32'(grant_o), 32'(0));
    chk("rst_mvalid", 32'(m_valid_o), 32'(0));
    chk("rst_mdata", 32'(m_data_o), 32'(0));
    chk("rst_s0_ready", 32'(s0_ready_o), 32'(0));
    chk("rst_s1_ready", 32'(s1_ready_o), 32'(0));
    exp_q.delete();
    m_rr = 1'b0; m_bc = 0; m_ic = 0;
    rstn_i = 1'b1;
  endtask

  task automatic run_drain(input string tag, input int budget, output int n);
    n = 0;
    while ((src0_q.size() != 0 || src1_q.size() != 0 || m_valid_o) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, 32'(src0_q.size() + src1_q.size() + int'(m_valid_o)), 32'(0));
  endtask

  initial begin
    int n;
    rstn_i = 1'b0; m_ready_i = 1'b1; s0_hold = 1'b0; s1_hold = 1'b0;
    s0_data_i = 8'h00; s1_data_i = 8'h00;
    s0_valid_i = 1'b0; s1_valid_i = 1'b0; s0_last_i = 1'b0; s1_last_i = 1'b0;
    m_rr = 1'b0; m_bc = 0; m_ic = 0; n_cyc = 0;

    do_reset(3);

    // Lone source 0: 01..07, last on 07
    push_src(0, 8'h01, 7, 1'b1);
    run_drain("lone_s0", 100, n);
    chk("lone_s0_cycles", 32'(n), LOCK ? 32'(9) : 32'(15));
    chk("lone_s0_idle", 32'(grant_o), 32'(0));

    // Contention straight out of reset: source 0 wins the first tie
    do_reset(2);
    push_src(0, 8'hA0, 2, 1'b1);
    push_src(1, 8'hB0, 2, 1'b1);
    tick();
    chk("contend_first", 32'(grant_o), 32'(2'b01));
    run_drain("contend", 100, n);

    // Burst cap: source 1 streams 20 bytes, source 0 joins later
    s0_hold = 1'b1;
    push_src(1, 8'h40, 20, 1'b0);
    push_src(0, 8'h80, 2, 1'b1);
    tick(); tick(); tick();
    s0_hold = 1'b0;
    run_drain("burst", 300, n);

    // Backpressure mid-burst
    push_src(0, 8'hC0, 10, 1'b1);
    tick(); tick(); tick();
    m_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    m_ready_i = 1'b1;
    run_drain("bp", 100, n);

    // Idle release: source 0 drops valid for 4 cycles mid-grant
    push_src(0, 8'hD0, 6, 1'b1);
    tick(); tick(); tick();
    s0_hold = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("idle_release", 32'(grant_o), 32'(0));
    s0_hold = 1'b0;
    run_drain("idle", 100, n);

    // Both sources with short packets: alternation depends on mode
    push_src(0, 8'h10, 3, 1'b1);
    push_src(1, 8'h20, 3, 1'b1);
    run_drain("alt", 100, n);

    // Reset with a byte buffered: that byte is dropped, the rest still flows
    m_ready_i = 1'b0;
    push_src(1, 8'hE0, 4, 1'b1);
    tick(); tick(); tick();
    chk("pre_rst_valid", 32'(m_valid_o), 32'(1));
    do_reset(2);
    m_ready_i = 1'b1;
    tick();
    chk("post_rst_grant", 32'(grant_o), 32'(2'b10));
    run_drain("post_rst", 100, n);

    chk("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
